vector_issue_ctrl: RTL and testbench
====================================

# vector_issue_ctrl

Sequencer and port arbiter for the 8×256-bit vector register file. Accepts one vector instruction at a time, drives the register file read/write ports through read → execute → write-back, and shares the same ports with a host load/store port. Sits between instruction decode, the vector execution lanes and the register file; it is the register file's only driver.

## Interface

**Parameters**
- `DW`, 256, vector register width
- `AW`, 3, register address width (8 registers)
- `OPW`, 4, opcode width forwarded to the execution unit

**Ports**
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  instruction accepted when high with `instr_valid`
- `instr_op`  in  OPW  opcode
- `instr_srca`, `instr_srcb`, `instr_dst`  in  AW each  source A, source B, destination
- `instr_done`  out  1  one-cycle pulse, instruction retired
- `exec_start`  out  1  one-cycle pulse, operands valid on the register file's Va/Vb
- `exec_op`  out  OPW  latched opcode, stable from `exec_start` until write-back
- `exec_done`  in  1  result valid
- `exec_result`  in  DW  result data
- `host_req`  in  1  host access request, held until granted
- `host_we`  in  1  1 = write, 0 = read
- `host_addr`  in  AW  register address
- `host_wdata`  in  DW  write data
- `host_gnt`  out  1  one-cycle pulse, host request accepted
- `host_rvalid`  out  1  one-cycle pulse, `host_rdata` valid
- `host_rdata`  out  DW  read data
- `rf_rd_a`, `rf_rd_b`  out  AW each  register file read addresses
- `rf_we`  out  1  register file write enable
- `rf_wr_addr`  out  AW  write address
- `rf_wr_data`  out  DW  write data
- `rf_va`  in  DW  register file port A data, one cycle after address
- `busy`  out  1  state ≠ IDLE

## Operation

- States: IDLE, RD, OPND, EXEC, WB, HWR, HRD, HRDW.
- IDLE arbitration when both `instr_valid` and `host_req` are high: the side not served last wins. A 1-bit `last_host` flag resets to 0, so the host wins the first tie. A single requester always wins.
- Instruction accept (`instr_valid & instr_ready`): latch op/srca/srcb/dst; go to RD.
- RD: `rf_rd_a`=srca, `rf_rd_b`=srcb; go to OPND.
- OPND: Va/Vb are valid. Pulse `exec_start`; go to EXEC.
- EXEC: wait for `exec_done`. Then latch `exec_result` and go to WB. `exec_done` is ignored in every other state.
- WB: `rf_we`=1, `rf_wr_addr`=dst, `rf_wr_data`=latched result. Pulse `instr_done`; go to IDLE.
- Host grant: pulse `host_gnt` and latch addr/we/wdata.
  - Write: HWR drives `rf_we`, `rf_wr_addr`, `rf_wr_data`, then IDLE.
  - Read: HRD drives `rf_rd_a`=addr. HRDW registers `rf_va` into `host_rdata`, pulses `host_rvalid` (data visible the cycle after HRDW), then IDLE.
- Outputs are 0 outside their driving states. `host_rdata` holds its last value.
- `instr_ready` = (state==IDLE) & instruction wins arbitration. It is combinational and is 0 while `rst_n`=0.
- No internal hazard checks are needed: operations are strictly serialized, and a WB or HWR write lands before the next RD address is sampled.
- Reset (async, any state): state → IDLE, `last_host` → 0, all outputs → 0 including `host_rdata` and `exec_op`. An in-flight instruction or host access is dropped with no write. A pending `exec_done` after reset is ignored.

## Timing

- Instruction accepted in cycle T:
  - RD at T+1.
  - `exec_start` at T+2.
  - `exec_done` at T+2+k (k ≥ 1) → WB/`rf_we`/`instr_done` at T+3+k.
  - IDLE at T+4+k.
- Minimum instruction occupancy: 5 cycles (k=1).
- Host write granted at T: `rf_we` at T+1, IDLE at T+2.
- Host read granted at T: `rf_rd_a` at T+1, HRDW at T+2, `host_rvalid`/`host_rdata` at T+3, next grant possible at T+3.
- Back-to-back: a new grant is possible the first IDLE cycle after completion. There is no IDLE bypass.

## Structure

- Shared package `vec_pkg`:
  - `DW`, `AW`, `OPW` defaults
  - state encoding enum
  - `VEC_NREGS` = 8
- Single module; no sub-module. The arbiter is a few lines inside IDLE decode.

## Test plan

- Reset values: assert `rst_n`=0 with all inputs random → every output 0, `busy`=0, `instr_ready`=0.
- Host write then read: host writes reg 5 = 256'hA5…A5; host reads reg 5 → `rf_we` at grant+1 with addr 5; `host_rvalid` at grant+3 with `host_rdata`=A5…A5.
- Instruction k=1: op=2, srca=1, srcb=2, dst=3; `exec_done` the cycle after `exec_start` with result 256'h1234 → `rf_rd_a`=1/`rf_rd_b`=2 at T+1, `exec_start` at T+2, `rf_we` with addr 3 and data 256'h1234 at T+4, `instr_done` at T+4.
- Tie fairness: `host_req` and `instr_valid` held continuously → grants alternate host, instr, host, instr; `instr_ready` is never high on a host-grant cycle.
- Long execute: `exec_done` delayed 20 cycles, with `host_req` raised mid-EXEC → no `host_gnt` until after WB; `exec_op` stable throughout.
- Reset mid-op: `rst_n` low during EXEC, then `exec_done` pulsed after release → no `rf_we`, no `instr_done`, state IDLE, `busy`=0.

Source files
------------

// File: rtl/vector_issue_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_pkg : shared sizes and sequencer state encoding for vector_issue_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package vec_pkg;

  localparam int VEC_DW    = 256;
  localparam int VEC_AW    = 3;
  localparam int VEC_OPW   = 4;
  localparam int VEC_NREGS = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_OPND = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_HWR  = 3'd5,
    ST_HRD  = 3'd6,
    ST_HRDW = 3'd7
  } vic_state_e;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vector_issue_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_issue_ctrl_if : instruction, execution, host and register-file bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface vector_issue_ctrl_if #(
  parameter int DW  = vec_pkg::VEC_DW,
  parameter int AW  = vec_pkg::VEC_AW,
  parameter int OPW = vec_pkg::VEC_OPW
) ();

  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] instr_op;
  logic [AW-1:0]  instr_srca;
  logic [AW-1:0]  instr_srcb;
  logic [AW-1:0]  instr_dst;
  logic           instr_done;

  logic           exec_start;
  logic [OPW-1:0] exec_op;
  logic           exec_done;
  logic [DW-1:0]  exec_result;

  logic           host_req;
  logic           host_we;
  logic [AW-1:0]  host_addr;
  logic [DW-1:0]  host_wdata;
  logic           host_gnt;
  logic           host_rvalid;
  logic [DW-1:0]  host_rdata;

  logic [AW-1:0]  rf_rd_a;
  logic [AW-1:0]  rf_rd_b;
  logic           rf_we;
  logic [AW-1:0]  rf_wr_addr;
  logic [DW-1:0]  rf_wr_data;
  logic [DW-1:0]  rf_va;

  logic           busy;

  modport slave (
    input  instr_valid, instr_op, instr_srca, instr_srcb, instr_dst,
    output instr_ready, instr_done,
    output exec_start, exec_op,
    input  exec_done, exec_result,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output rf_rd_a, rf_rd_b, rf_we, rf_wr_addr, rf_wr_data,
    input  rf_va,
    output busy
  );

  modport master (
    output instr_valid, instr_op, instr_srca, instr_srcb, instr_dst,
    input  instr_ready, instr_done,
    input  exec_start, exec_op,
    output exec_done, exec_result,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  rf_rd_a, rf_rd_b, rf_we, rf_wr_addr, rf_wr_data,
    output rf_va,
    input  busy
  );

endinterface : vector_issue_ctrl_if
`default_nettype wire

// File: rtl/vector_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_issue_ctrl : serial vector-instruction sequencer sharing RF ports with a host
// Rev 1.0
// ---------------------------------------------------------------------------
module vector_issue_ctrl
  import vec_pkg::*;
#(
  parameter int DW  = VEC_DW,
  parameter int AW  = VEC_AW,
  parameter int OPW = VEC_OPW
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  vector_issue_ctrl_if.slave bus
);

  vic_state_e     r_state;
  vic_state_e     w_next;
  logic           r_last_host;
  logic [OPW-1:0] r_op;
  logic [AW-1:0]  r_srca;
  logic [AW-1:0]  r_srcb;
  logic [AW-1:0]  r_wr_addr;
  logic [DW-1:0]  r_wr_data;
  logic [DW-1:0]  r_host_rdata;
  logic           r_host_rvalid;
  logic           w_idle;
  logic           w_host_win;
  logic           w_instr_ready;
  logic           w_instr_acc;

  // Gating with rst_n keeps the combinational handshakes low while reset is held.
  assign w_idle        = rst_n && (r_state == ST_IDLE);
  assign w_host_win    = w_idle && bus.host_req && (!bus.instr_valid || !r_last_host);
  assign w_instr_ready = w_idle && !w_host_win;
  assign w_instr_acc   = w_instr_ready && bus.instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_last_host   <= 1'b0;
      r_op          <= '0;
      r_srca        <= '0;
      r_srcb        <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_host_rvalid <= (r_state == ST_HRDW);
      if (w_host_win) begin
        r_last_host <= 1'b1;
        r_srca      <= bus.host_addr;
        r_wr_addr   <= bus.host_addr;
        r_wr_data   <= bus.host_wdata;
      end else if (w_instr_acc) begin
        r_last_host <= 1'b0;
        r_op        <= bus.instr_op;
        r_srca      <= bus.instr_srca;
        r_srcb      <= bus.instr_srcb;
        r_wr_addr   <= bus.instr_dst;
      end
      if ((r_state == ST_EXEC) && bus.exec_done) begin
        r_wr_data <= bus.exec_result;
      end
      if (r_state == ST_HRDW) begin
        r_host_rdata <= bus.rf_va;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.instr_ready = w_instr_ready;
    bus.host_gnt    = w_host_win;
    bus.instr_done  = 1'b0;
    bus.exec_start  = 1'b0;
    bus.exec_op     = '0;
    bus.rf_rd_a     = '0;
    bus.rf_rd_b     = '0;
    bus.rf_we       = 1'b0;
    bus.rf_wr_addr  = '0;
    bus.rf_wr_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_host_win) begin
          w_next = bus.host_we ? ST_HWR : ST_HRD;
        end else if (w_instr_acc) begin
          w_next = ST_RD;
        end
      end
      ST_RD: begin
        bus.rf_rd_a = r_srca;
        bus.rf_rd_b = r_srcb;
        w_next      = ST_OPND;
      end
      ST_OPND: begin
        bus.exec_start = 1'b1;
        bus.exec_op    = r_op;
        w_next         = ST_EXEC;
      end
      ST_EXEC: begin
        bus.exec_op = r_op;
        if (bus.exec_done) begin
          w_next = ST_WB;
        end
      end
      ST_WB: begin
        bus.exec_op    = r_op;
        bus.rf_we      = 1'b1;
        bus.rf_wr_addr = r_wr_addr;
        bus.rf_wr_data = r_wr_data;
        bus.instr_done = 1'b1;
        w_next         = ST_IDLE;
      end
      ST_HWR: begin
        bus.rf_we      = 1'b1;
        bus.rf_wr_addr = r_wr_addr;
        bus.rf_wr_data = r_wr_data;
        w_next         = ST_IDLE;
      end
      ST_HRD: begin
        bus.rf_rd_a = r_srca;
        w_next      = ST_HRDW;
      end
      ST_HRDW: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule : vector_issue_ctrl
`default_nettype wire

// File: tb/tb_vector_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vector_issue_ctrl : randomized transaction-level bench for vector_issue_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vector_issue_ctrl;
  import vec_pkg::*;

  localparam int DW  = VEC_DW;
  localparam int AW  = VEC_AW;
  localparam int OPW = VEC_OPW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_issue_ctrl_if #(.DW(DW), .AW(AW), .OPW(OPW)) bus ();

  vector_issue_ctrl #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Register file: read data appears one cycle after the address.
  logic [DW-1:0] rf_mem [VEC_NREGS];
  logic          init_we = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [DW-1:0] init_data = '0;
  always @(posedge clk) begin
    if (init_we) rf_mem[init_addr] <= init_data;
    else if (bus.rf_we) rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
    bus.rf_va <= rf_mem[bus.rf_rd_a];
  end

  logic [DW-1:0] ref_rf [VEC_NREGS];
  bit            tb_last_host;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rand_host_fields();
    bus.host_we    = 1'($urandom_range(0, 1));
    bus.host_addr  = AW'($urandom_range(0, VEC_NREGS - 1));
    bus.host_wdata = rand_dw();
  endtask

  task automatic rand_instr_fields();
    bus.instr_op   = OPW'($urandom_range(0, 15));
    bus.instr_srca = AW'($urandom_range(0, VEC_NREGS - 1));
    bus.instr_srcb = AW'($urandom_range(0, VEC_NREGS - 1));
    bus.instr_dst  = AW'($urandom_range(0, VEC_NREGS - 1));
  endtask

  task automatic wait_grant(output bit got_host, output int waited);
    waited = 0;
    while (!bus.host_gnt && !(bus.instr_valid && bus.instr_ready) && waited < 64) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 64) begin
      n_vec++; n_err++;
      $display("FAIL grant_timeout: got no grant after %0d cycles expected a grant", waited);
    end
    got_host = bus.host_gnt;
    check_val("gnt_exclusive", bus.host_gnt & bus.instr_ready, 0);
  endtask

  // Entered at the grant cycle; returns at the first cycle a new grant may occur.
  task automatic host_phase(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input bit keep);
    @(negedge clk);
    if (!keep) bus.host_req = 1'b0;
    rand_host_fields();
    #1;
    check_val("hst_busy1", bus.busy, 1);
    check_val("hst_gnt_low", bus.host_gnt, 0);
    if (we) begin
      check_val("hwr_we", bus.rf_we, 1);
      check_val("hwr_addr", bus.rf_wr_addr, addr);
      check_val("hwr_data", bus.rf_wr_data, data);
      check_val("hwr_ready_low", bus.instr_ready, 0);
      ref_rf[addr] = data;
      @(negedge clk); #1;
      check_val("hwr_idle", bus.busy, 0);
    end else begin
      check_val("hrd_addr", bus.rf_rd_a, addr);
      check_val("hrd_we_low", bus.rf_we, 0);
      @(negedge clk); #1;
      check_val("hrdw_rvalid_low", bus.host_rvalid, 0);
      check_val("hrdw_busy", bus.busy, 1);
      @(negedge clk); #1;
      check_val("hrd_rvalid", bus.host_rvalid, 1);
      check_val("hrd_rdata", bus.host_rdata, ref_rf[addr]);
      check_val("hrd_idle", bus.busy, 0);
    end
  endtask

  task automatic instr_phase(input logic [OPW-1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [AW-1:0] d, input int k, input logic [DW-1:0] res,
                             input bit keep, input bit host_mid);
    @(negedge clk);
    if (!keep) bus.instr_valid = 1'b0;
    rand_instr_fields();
    bus.exec_done   = 1'($urandom_range(0, 1));
    bus.exec_result = rand_dw();
    #1;
    check_val("rd_a", bus.rf_rd_a, a);
    check_val("rd_b", bus.rf_rd_b, b);
    check_val("rd_busy", bus.busy, 1);
    check_val("rd_ready_low", bus.instr_ready, 0);
    check_val("rd_start_low", bus.exec_start, 0);
    @(negedge clk);
    bus.exec_done = 1'($urandom_range(0, 1));
    #1;
    check_val("opnd_start", bus.exec_start, 1);
    check_val("opnd_op", bus.exec_op, op);
    check_val("opnd_va", bus.rf_va, ref_rf[a]);
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      if (host_mid && j == (k + 1) / 2) begin
        bus.host_req = 1'b1;
        rand_host_fields();
      end
      bus.exec_done   = (j == k);
      bus.exec_result = (j == k) ? res : rand_dw();
      #1;
      check_val("exec_start_low", bus.exec_start, 0);
      check_val("exec_op_hold", bus.exec_op, op);
      check_val("exec_we_low", bus.rf_we, 0);
      check_val("exec_gnt_low", bus.host_gnt, 0);
      check_val("exec_done_low", bus.instr_done, 0);
    end
    @(negedge clk);
    bus.exec_done   = 1'b0;
    bus.exec_result = rand_dw();
    #1;
    check_val("wb_we", bus.rf_we, 1);
    check_val("wb_addr", bus.rf_wr_addr, d);
    check_val("wb_data", bus.rf_wr_data, res);
    check_val("wb_done", bus.instr_done, 1);
    check_val("wb_op", bus.exec_op, op);
    check_val("wb_gnt_low", bus.host_gnt, 0);
    ref_rf[d] = res;
    @(negedge clk); #1;
    check_val("post_idle", bus.busy, 0);
    check_val("post_done_low", bus.instr_done, 0);
  endtask

  // Serves every pending request; the first n_keep grants re-request immediately.
  task automatic serve_pending(input int n_keep);
    bit got_host;
    bit exp_host;
    int waited;
    int served;
    served = 0;
    while (bus.host_req || bus.instr_valid) begin
      exp_host = bus.host_req && (!bus.instr_valid || !tb_last_host);
      wait_grant(got_host, waited);
      if (waited >= 64) return;
      check_val("grant_wait", waited, 0);
      check_val("grant_side", got_host, exp_host);
      tb_last_host = got_host;
      if (got_host)
        host_phase(bus.host_we, bus.host_addr, bus.host_wdata, served < n_keep);
      else
        instr_phase(bus.instr_op, bus.instr_srca, bus.instr_srcb, bus.instr_dst,
                    $urandom_range(1, 3), rand_dw(), served < n_keep, 1'b0);
      served++;
    end
  endtask

  initial begin
    bit got_host;
    int waited;
    bus.instr_valid = 1'b0;
    bus.host_req    = 1'b0;
    bus.exec_done   = 1'b0;
    bus.exec_result = '0;
    rand_instr_fields();
    rand_host_fields();

    // Reset with random inputs; also preload the register file.
    for (int i = 0; i < VEC_NREGS; i++) begin
      @(negedge clk);
      init_we   = 1'b1;
      init_addr = AW'(i);
      init_data = rand_dw();
      ref_rf[i] = init_data;
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.host_req    = 1'($urandom_range(0, 1));
      bus.exec_done   = 1'($urandom_range(0, 1));
      bus.exec_result = rand_dw();
      rand_instr_fields();
      rand_host_fields();
    end
    #1;
    check_val("rst_ready", bus.instr_ready, 0);
    check_val("rst_gnt", bus.host_gnt, 0);
    check_val("rst_done", bus.instr_done, 0);
    check_val("rst_start", bus.exec_start, 0);
    check_val("rst_op", bus.exec_op, 0);
    check_val("rst_rvalid", bus.host_rvalid, 0);
    check_val("rst_rdata", bus.host_rdata, 0);
    check_val("rst_rda", bus.rf_rd_a, 0);
    check_val("rst_rdb", bus.rf_rd_b, 0);
    check_val("rst_we", bus.rf_we, 0);
    check_val("rst_waddr", bus.rf_wr_addr, 0);
    check_val("rst_wdata", bus.rf_wr_data, 0);
    check_val("rst_busy", bus.busy, 0);
    @(negedge clk);
    init_we = 1'b0;
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    bus.host_req    = 1'b0;
    bus.exec_done   = 1'b0;
    tb_last_host = 1'b0;
    #1;

    // Host write then read of register 5.
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 3'd5;
    bus.host_wdata = {32{8'hA5}};
    #1;
    serve_pending(0);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 3'd5;
    #1;
    serve_pending(0);
    check_val("a5_readback", bus.host_rdata, {32{8'hA5}});

    // Directed instruction with a one-cycle execute.
    bus.instr_valid = 1'b1; bus.instr_op = 4'd2;
    bus.instr_srca = 3'd1; bus.instr_srcb = 3'd2; bus.instr_dst = 3'd3;
    #1;
    wait_grant(got_host, waited);
    check_val("k1_side", got_host, 0);
    tb_last_host = 1'b0;
    instr_phase(4'd2, 3'd1, 3'd2, 3'd3, 1, 256'h1234, 1'b0, 1'b0);

    // Random mix of host-only, instruction-only and contended requests.
    for (int n = 0; n < 30; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      rand_instr_fields();
      rand_host_fields();
      bus.host_req    = (mode != 1);
      bus.instr_valid = (mode != 0);
      #1;
      serve_pending(0);
    end

    // Long execute with a host request arriving mid-EXEC.
    rand_instr_fields();
    bus.instr_valid = 1'b1;
    #1;
    wait_grant(got_host, waited);
    check_val("long_side", got_host, 0);
    tb_last_host = 1'b0;
    instr_phase(bus.instr_op, bus.instr_srca, bus.instr_srcb, bus.instr_dst, 20, rand_dw(), 1'b0, 1'b1);
    check_val("long_host_pending", bus.host_req, 1);
    serve_pending(0);

    // Reset while executing; a late exec_done must not cause a write.
    rand_instr_fields();
    bus.instr_valid = 1'b1;
    #1;
    wait_grant(got_host, waited);
    check_val("rstmid_side", got_host, 0);
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_val("rstmid_busy", bus.busy, 0);
    check_val("rstmid_op", bus.exec_op, 0);
    check_val("rstmid_rdata", bus.host_rdata, 0);
    @(negedge clk); rst_n = 1'b1; bus.exec_done = 1'b1; bus.exec_result = rand_dw();
    tb_last_host = 1'b0;
    #1;
    check_val("rstmid_busy2", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.exec_done = 1'b0; #1;
      check_val("rstmid_we", bus.rf_we, 0);
      check_val("rstmid_done", bus.instr_done, 0);
      check_val("rstmid_idle", bus.busy, 0);
    end

    // Continuous contention: grants alternate host, instr, host, instr, ...
    rand_instr_fields();
    rand_host_fields();
    bus.host_req = 1'b1;
    bus.instr_valid = 1'b1;
    #1;
    serve_pending(4);

    // Sweep every register through the host port against the reference.
    for (int i = 0; i < VEC_NREGS; i++) begin
      bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = AW'(i);
      #1;
      serve_pending(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_vector_issue_ctrl
`default_nettype wire
